pipe_ctrl: RTL and testbench

- Consumer end of the hazard stall interface.
- Takes the per-stage stall request vector, the ID-stage branch redirect and the data-memory ready handshake.
- Drives a per-register enable and bubble (flush) for the five pipeline registers of the 5-stage core.
- Owns the memory-wait FSM and its timeout watchdog, so the hazard logic stays purely combinational.

---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/pipe_ctrl_sat_counter.sv | 22 ++
 rtl/pipe_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall-vector macros,
// FSM state type and pipeline-register indices.
`ifndef PIPE_CTRL_DEFINES
`define PIPE_CTRL_DEFINES
`define STALL_WIDTH  5
`define STALL_NOP    5'b00000
`define STALL_LOAD   5'b00011
`define STALL_BRANCH 5'b00011
`endif

package pipe_ctrl_pkg;

    localparam int unsigned STALL_W = `STALL_WIDTH;

    // Pipeline register indices within stage_en / stage_flush
    localparam int unsigned STG_PC    = 0;
    localparam int unsigned STG_IFID  = 1;
    localparam int unsigned STG_IDEX  = 2;
    localparam int unsigned STG_EXMEM = 3;
    localparam int unsigned STG_MEMWB = 4;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module sat_counter #(
    parameter int unsigned W   = 32,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count up on inc, stick at MAX, clear has priority over inc
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline register enable/flush controller with data-memory wait FSM
// and timeout watchdog. Define PIPE_PERF_EN to add four saturating
// performance counters as extra output ports.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NSTAGE      = `STALL_WIDTH,
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stall_req,
    input  logic              branch_taken,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic [NSTAGE-1:0] stage_en,
    output logic [NSTAGE-1:0] stage_flush,
    output logic              pc_redirect,
    output logic              mem_timeout,
    output logic [1:0]        state_o
`ifdef PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_load_stall,
    output logic [CNT_W-1:0]  perf_mem_wait,
    output logic [CNT_W-1:0]  perf_flush,
    output logic [CNT_W-1:0]  perf_cycles
`endif
);

    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MEM_TIMEOUT - 1);

    pipe_state_t      state;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_busy;
    logic             wait_inc;
    logic             wait_clr;

    // A dropped request in MEM_WAIT releases the pipe just like ready does
    assign mem_busy = dmem_req & ~dmem_ready;
    assign state_o  = state;

    // Wait counter: count busy cycles outside TIMEOUT, clear on release
    always_comb begin
        wait_inc = 1'b0;
        wait_clr = 1'b0;
        if (state == RUN || state == MEM_WAIT) begin
            wait_inc = mem_busy;
            wait_clr = ~mem_busy;
        end
    end

    sat_counter #(
        .W   (CNT_W),
        .MAX (WAIT_MAX)
    ) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .clr (wait_clr),
        .inc (wait_inc),
        .cnt (wait_cnt)
    );

    // Memory-wait FSM and sticky watchdog flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_busy) state <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (!mem_busy) begin
                        state <= RUN;
                    end else if (wait_cnt == WAIT_MAX) begin
                        state       <= TIMEOUT;
                        mem_timeout <= 1'b1;
                    end
                end
                TIMEOUT: begin
                    state <= TIMEOUT;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Register enables, bubbles and redirect from state plus inputs
    always_comb begin
        stage_en    = '0;
        stage_flush = '0;
        pc_redirect = 1'b0;
        if (rst) begin
            stage_flush = '1;
        end else if (state == TIMEOUT || mem_busy) begin
            stage_en    = '0;
            stage_flush = '0;
        end else begin
            stage_en    = ~stall_req;
            // Bubble into the first free register behind a held one
            stage_flush = NSTAGE'(stall_req << 1) & ~stall_req;
            if (branch_taken && !stall_req[STG_IFID]) begin
                pc_redirect           = 1'b1;
                stage_flush[STG_IFID] = 1'b1;
            end
        end
    end

`ifdef PIPE_PERF_EN
    logic perf_active;
    logic ls_inc;
    logic mw_inc;

    // Counters advance only while the watchdog has not tripped
    always_comb begin
        perf_active = (state != TIMEOUT);
        ls_inc      = (state == RUN) && (|stall_req) && !mem_busy;
        mw_inc      = perf_active && mem_busy;
    end

    sat_counter #(.W(CNT_W)) u_perf_load_stall (
        .clk (clk), .rst (rst), .clr (1'b0), .inc (ls_inc), .cnt (perf_load_stall)
    );
    sat_counter #(.W(CNT_W)) u_perf_mem_wait (
        .clk (clk), .rst (rst), .clr (1'b0), .inc (mw_inc), .cnt (perf_mem_wait)
    );
    sat_counter #(.W(CNT_W)) u_perf_flush (
        .clk (clk), .rst (rst), .clr (1'b0), .inc (pc_redirect), .cnt (perf_flush)
    );
    sat_counter #(.W(CNT_W)) u_perf_cycles (
        .clk (clk), .rst (rst), .clr (1'b0), .inc (perf_active), .cnt (perf_cycles)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (MEM_TIMEOUT = 4).
module tb_pipe_ctrl;

    localparam int unsigned NS    = 5;
    localparam int unsigned CNT_W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] stall_req;
    logic          branch_taken;
    logic          dmem_req;
    logic          dmem_ready;
    logic [NS-1:0] stage_en;
    logic [NS-1:0] stage_flush;
    logic          pc_redirect;
    logic          mem_timeout;
    logic [1:0]    state_o;
`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] perf_load_stall, perf_mem_wait, perf_flush, perf_cycles;
`endif

    pipe_ctrl #(.NSTAGE(NS), .MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_req    (stall_req),
        .branch_taken (branch_taken),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .stage_en     (stage_en),
        .stage_flush  (stage_flush),
        .pc_redirect  (pc_redirect),
        .mem_timeout  (mem_timeout),
        .state_o      (state_o)
`ifdef PIPE_PERF_EN
        ,
        .perf_load_stall (perf_load_stall),
        .perf_mem_wait   (perf_mem_wait),
        .perf_flush      (perf_flush),
        .perf_cycles     (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [NS-1:0] stall;
        logic          br;
        logic          req;
        logic          rdy;
        logic [NS-1:0] en;
        logic [NS-1:0] fl;
        logic          rd;
        logic          chk_st;
        logic [1:0]    st;
        logic          to;
    } vec_t;

    vec_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_no  = 0;

    function automatic vec_t mk(logic r, logic [NS-1:0] s, logic b, logic rq, logic ry,
                                logic [NS-1:0] e, logic [NS-1:0] f, logic rd,
                                logic cs, logic [1:0] st, logic to);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.req = rq; v.rdy = ry;
        v.en = e; v.fl = f; v.rd = rd; v.chk_st = cs; v.st = st; v.to = to;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL step%0d %s got=%0h exp=%0h", step_no, nm, got, exp);
        end
    endtask

    // Drive one cycle, queue its expectation, compare once outputs settle
    task automatic apply(input vec_t v);
        vec_t e;
        rst = v.rst; stall_req = v.stall; branch_taken = v.br;
        dmem_req = v.req; dmem_ready = v.rdy;
        q.push_back(v);
        #1;
        e = q.pop_front();
        chk("stage_en",    32'(stage_en),    32'(e.en));
        chk("stage_flush", 32'(stage_flush), 32'(e.fl));
        chk("pc_redirect", 32'(pc_redirect), 32'(e.rd));
        if (e.chk_st) begin
            chk("state_o",     32'(state_o),     32'(e.st));
            chk("mem_timeout", 32'(mem_timeout), 32'(e.to));
        end
        @(posedge clk);
        #1;
        step_no++;
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b1; stall_req = '0; branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;

        //           rst stall     br rq ry  en        flush     rd cs st to
        tbl.push_back(mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b11111, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b11111, 0, 1, 0, 0));
        tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 5'b00011, 0, 0, 0, 5'b11100, 5'b00100, 0, 1, 0, 0));
        tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 5'b00000, 1, 0, 0, 5'b11111, 5'b00010, 1, 1, 0, 0));
        tbl.push_back(mk(0, 5'b00011, 1, 0, 0, 5'b11100, 5'b00100, 0, 1, 0, 0));
        tbl.push_back(mk(0, 5'b00001, 0, 0, 0, 5'b11110, 5'b00010, 0, 1, 0, 0));
        tbl.push_back(mk(0, 5'b01000, 0, 0, 0, 5'b10111, 5'b10000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 5'b11111, 0, 0, 0, 5'b00000, 5'b00000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 5'b00101, 0, 0, 0, 5'b11010, 5'b01010, 0, 1, 0, 0));
        // memory wait of three busy cycles, then ready
        tbl.push_back(mk(0, 5'b00000, 0, 1, 0, 5'b00000, 5'b00000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 5'b00000, 0, 1, 0, 5'b00000, 5'b00000, 0, 1, 1, 0));
        tbl.push_back(mk(0, 5'b00000, 0, 1, 0, 5'b00000, 5'b00000, 0, 1, 1, 0));
        tbl.push_back(mk(0, 5'b00000, 0, 1, 1, 5'b11111, 5'b00000, 0, 1, 1, 0));
        tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 0, 1, 0, 0));
        // wait with load stall and branch held: frozen, then normal rules on ready
        tbl.push_back(mk(0, 5'b00011, 1, 1, 0, 5'b00000, 5'b00000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 5'b00011, 1, 1, 0, 5'b00000, 5'b00000, 0, 1, 1, 0));
        tbl.push_back(mk(0, 5'b00011, 1, 1, 1, 5'b11100, 5'b00100, 0, 1, 1, 0));
        tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 0, 1, 0, 0));
        // request dropped mid-wait acts as ready
        tbl.push_back(mk(0, 5'b00000, 0, 1, 0, 5'b00000, 5'b00000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 5'b00000, 1, 0, 0, 5'b11111, 5'b00010, 1, 1, 1, 0));
        tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 0, 1, 0, 0));

        foreach (tbl[i]) begin
            apply(tbl[i]);
`ifdef PIPE_PERF_EN
            if (i == 14) chk("perf_mem_wait", perf_mem_wait, 32'd3);
`endif
        end

        // Watchdog: four busy cycles trip TIMEOUT, which holds through ready
        apply(mk(0, 5'b00000, 0, 1, 0, 5'b00000, 5'b00000, 0, 1, 0, 0));
        apply(mk(0, 5'b00000, 0, 1, 0, 5'b00000, 5'b00000, 0, 1, 1, 0));
        apply(mk(0, 5'b00000, 0, 1, 0, 5'b00000, 5'b00000, 0, 1, 1, 0));
        apply(mk(0, 5'b00000, 0, 1, 0, 5'b00000, 5'b00000, 0, 1, 1, 0));
        apply(mk(0, 5'b00000, 0, 1, 0, 5'b00000, 5'b00000, 0, 1, 2, 1));
        apply(mk(0, 5'b00000, 1, 1, 1, 5'b00000, 5'b00000, 0, 1, 2, 1));
        apply(mk(0, 5'b00000, 1, 0, 0, 5'b00000, 5'b00000, 0, 1, 2, 1));
        // Reset pulse clears TIMEOUT and the sticky flag
        apply(mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b11111, 0, 1, 2, 1));
        apply(mk(0, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 0, 1, 0, 0));

        // Reset mid-wait must also clear the wait counter
        apply(mk(0, 5'b00000, 0, 1, 0, 5'b00000, 5'b00000, 0, 1, 0, 0));
        apply(mk(0, 5'b00000, 0, 1, 0, 5'b00000, 5'b00000, 0, 1, 1, 0));
        apply(mk(1, 5'b00000, 0, 1, 0, 5'b00000, 5'b11111, 0, 1, 1, 0));
        apply(mk(0, 5'b00000, 0, 1, 0, 5'b00000, 5'b00000, 0, 1, 0, 0));
        apply(mk(0, 5'b00000, 0, 1, 0, 5'b00000, 5'b00000, 0, 1, 1, 0));
        apply(mk(0, 5'b00000, 0, 1, 0, 5'b00000, 5'b00000, 0, 1, 1, 0));
        apply(mk(0, 5'b00000, 0, 1, 0, 5'b00000, 5'b00000, 0, 1, 1, 0));
        apply(mk(0, 5'b00000, 0, 1, 0, 5'b00000, 5'b00000, 0, 1, 2, 1));
        apply(mk(1, 5'b00000, 0, 0, 0, 5'b00000, 5'b11111, 0, 1, 2, 1));
        apply(mk(0, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 0, 1, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
